// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NREQ req/done requesters onto one APB completer,
// sequences SETUP/ACCESS, and aborts transfers the completer does not finish within TIMEOUT cycles.
module apb_rr_master #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        req_rnw_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*32-1:0]     req_wdata_i,
  output logic [NREQ-1:0]        done_o,
  output logic                   err_o,
  output logic [31:0]            rdata_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [ADDR_W-1:0]      paddr_o,
  output logic [31:0]            pwdata_o,
  input  logic [31:0]            prdata_i,
  input  logic                   pready_i
);

  localparam int unsigned PTR_W = $clog2(NREQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ - 1);
  localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W:0]   NREQ_W = (PTR_W + 1)'(NREQ);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [31:0]       wdata_arr [NREQ];
  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    cand;
  logic [PTR_W-1:0]  next_ptr;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_arr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = req_wdata_i[k*32 +: 32];
  end

  // Candidate index is ptr+i reduced explicitly, so non-power-of-two NREQ wraps correctly.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!gnt_found && req_i[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign next_ptr = (owner_q == LAST) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    wdog_d    = wdog_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          owner_d  = gnt_idx;
          pwrite_d = ~req_rnw_i[gnt_idx];
          paddr_d  = addr_arr[gnt_idx];
          pwdata_d = wdata_arr[gnt_idx];
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wdog_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          done_d[owner_q] = 1'b1;
          rdata_d   = pwrite_q ? '0 : prdata_i;
          ptr_d     = next_ptr;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (wdog_q == WD_MAX) begin
          done_d[owner_q] = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          ptr_d     = next_ptr;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      wdog_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      wdog_q    <= wdog_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: memory-backed APB completer with programmable pready latency,
// scoreboard of expected completions checked whenever done_o pulses.
module tb_apb_rr_master;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_i;
  logic [NREQ-1:0]        req_rnw_i;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ*32-1:0]     req_wdata_i;
  logic [NREQ-1:0]        done_o;
  logic                   err_o;
  logic [31:0]            rdata_o;
  logic                   psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0]      paddr_o;
  logic [31:0]            pwdata_o;
  logic [31:0]            prdata_i;
  logic                   pready_i;

  always #5 clk = ~clk;

  apb_rr_master #(.NREQ(NREQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .req_rnw_i(req_rnw_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Completer: unwritten locations read back init_val; pready on ACCESS cycle 'lat' (0 = never).
  logic [31:0] mem [1024];
  logic        wr  [1024];
  int unsigned acc_cnt = 0;
  int unsigned lat = 1;
  logic        stray = 1'b0;

  assign pready_i = (psel_o && penable_o) ? (lat != 0 && acc_cnt == lat - 1) : stray;
  assign prdata_i = (wr[paddr_o] === 1'b1) ? mem[paddr_o] : init_val(paddr_o);

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) wr[i] <= 1'b0;
    end else if (psel_o && penable_o && pready_i && pwrite_o) begin
      mem[paddr_o] <= pwdata_o;
      wr[paddr_o]  <= 1'b1;
    end
    if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  typedef struct {
    logic [NREQ-1:0] done;
    logic            err;
    logic [31:0]     rdata;
  } sb_t;
  sb_t sb_q[$];

  task automatic expect_done(input int k, input logic err, input logic [31:0] rd);
    sb_t e;
    e.done    = '0;
    e.done[k] = 1'b1;
    e.err     = err;
    e.rdata   = rd;
    sb_q.push_back(e);
  endtask

  logic [ADDR_W-1:0] s_addr;
  logic              s_wr;
  logic [31:0]       s_wd;

  always @(negedge clk) begin
    sb_t e;
    if (psel_o && !penable_o) begin
      s_addr <= paddr_o;
      s_wr   <= pwrite_o;
      s_wd   <= pwdata_o;
    end else if (psel_o && penable_o) begin
      check("apb_stable", 32'(paddr_o == s_addr && pwrite_o == s_wr && pwdata_o == s_wd), 32'd1);
    end
    if (done_o != '0) begin
      check("psel_gap", 32'(psel_o), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexp_done", 32'(done_o), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_owner", 32'(done_o), 32'(e.done));
        check("err", 32'(err_o), 32'(e.err));
        check("rdata", rdata_o, e.rdata);
      end
    end
  end

  task automatic wait_dones(input int n, input int budget, output int acc);
    int seen = 0;
    acc = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      @(negedge clk);
      if (psel_o && penable_o) acc++;
      if (done_o != '0) seen++;
    end
    if (seen < n) check("wait_timeout", 32'(seen), 32'(n));
  endtask

  initial begin
    int acc;
    reset       = 1'b0;
    req_rnw_i   = '1;
    req_wdata_i = '0;
    for (int k = 0; k < NREQ; k++) req_addr_i[k*ADDR_W +: ADDR_W] = ADDR_W'(10 + k);
    req_i = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(psel_o), 32'd0);
    check("rst_penable", 32'(penable_o), 32'd0);
    check("rst_pwrite", 32'(pwrite_o), 32'd0);
    check("rst_paddr", 32'(paddr_o), 32'd0);
    check("rst_pwdata", pwdata_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);

    // All requesters active: strict rotation 0,1,2,3,0,1,2,3.
    for (int n = 0; n < 8; n++) expect_done(n % 4, 1'b0, init_val(ADDR_W'(10 + n % 4)));
    lat   = 2;
    reset = 1'b1;
    @(negedge clk);
    check("psel_rise", 32'(psel_o), 32'd1);
    check("penable_setup", 32'(penable_o), 32'd0);
    check("first_addr", 32'(paddr_o), 32'd10);
    wait_dones(8, 300, acc);
    req_i = '0;

    // Write then read back, with requester inputs scrambled while owned.
    repeat (2) @(negedge clk);
    req_rnw_i[0] = 1'b0;
    req_addr_i[0 +: ADDR_W] = ADDR_W'(3);
    req_wdata_i[0 +: 32] = 32'hDEADBEEF;
    lat = 5;
    expect_done(0, 1'b0, 32'd0);
    req_i = 4'b0001;
    @(negedge clk);
    req_rnw_i[0] = 1'b1;
    req_addr_i[0 +: ADDR_W] = ADDR_W'(7);
    req_wdata_i[0 +: 32] = 32'd0;
    check("pwrite_latched", 32'(pwrite_o), 32'd1);
    wait_dones(1, 100, acc);
    req_i = '0;
    check("wr_access_cycles", 32'(acc), 32'd5);
    req_addr_i[0 +: ADDR_W] = ADDR_W'(3);
    expect_done(0, 1'b0, 32'hDEADBEEF);
    req_i = 4'b0001;
    wait_dones(1, 100, acc);
    req_i = '0;
    check("rd_access_cycles", 32'(acc), 32'd5);
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata_o, 32'hDEADBEEF);
    req_addr_i[0 +: ADDR_W] = ADDR_W'(10);

    // Stuck completer: abort after exactly TIMEOUT ACCESS cycles, then next requester.
    lat = 0;
    expect_done(1, 1'b1, 32'd0);
    expect_done(2, 1'b0, init_val(ADDR_W'(12)));
    req_i = 4'b0110;
    wait_dones(1, 100, acc);
    req_i[1] = 1'b0;
    lat = 1;
    check("timeout_cycles", 32'(acc), TIMEOUT);
    wait_dones(1, 100, acc);
    req_i = '0;

    // pready on the last allowed ACCESS cycle succeeds; stray pready outside ACCESS ignored.
    stray = 1'b1;
    lat   = TIMEOUT;
    repeat (2) @(negedge clk);
    expect_done(3, 1'b0, init_val(ADDR_W'(13)));
    req_i = 4'b1000;
    wait_dones(1, 100, acc);
    req_i = '0;
    check("edge_access_cycles", 32'(acc), TIMEOUT);
    stray = 1'b0;

    // Move ptr off zero, then reset in the middle of an ACCESS.
    lat = 1;
    expect_done(1, 1'b0, init_val(ADDR_W'(11)));
    req_i = 4'b0010;
    wait_dones(1, 100, acc);
    req_i = '0;
    lat   = 0;
    req_i = 4'b0100;
    for (int c = 0; c < 10 && !(psel_o && penable_o); c++) @(negedge clk);
    check("reached_access", 32'(psel_o && penable_o), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_psel", 32'(psel_o), 32'd0);
    check("async_penable", 32'(penable_o), 32'd0);
    check("async_done", 32'(done_o), 32'd0);
    req_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    lat = 1;
    expect_done(0, 1'b0, init_val(ADDR_W'(10)));
    req_i = 4'b1001;
    wait_dones(1, 100, acc);
    req_i = '0;
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
